// File: rtl/axi_stream_pkg.sv
// axi_stream_pkg
// Shared helpers for the AXI4-Stream FIFO family:
//   clampW      - forces a sideband width of 0 up to 1 bit
//   clog2       - ceiling log2 for elaboration-time sizing
//   beatWidth   - total stored bits per beat (data, strb, keep, last, id, dest, user)
//   packBeat    - serialises beat fields into one vector, data in the LSBs
//   unpackField - extracts one field from a serialised beat
package axi_stream_pkg;

  // Upper bound on a serialised beat. The real beat width is sliced out by the caller.
  localparam int MAX_BEAT_W = 1024;
  typedef logic [MAX_BEAT_W-1:0] beatVec_t;

  function automatic int clampW(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int beatWidth(input int bytes, input int idW, input int destW,
                                   input int userW);
    return 8 * bytes + 2 * bytes + 1 + idW + destW + userW;
  endfunction

  // Fields must arrive zero-extended; layout LSB->MSB: data, strb, keep, last, id, dest, user.
  function automatic beatVec_t packBeat(input beatVec_t data, input beatVec_t strb,
                                        input beatVec_t keep, input beatVec_t last,
                                        input beatVec_t id, input beatVec_t dest,
                                        input beatVec_t user, input int dataW,
                                        input int bytes, input int idW, input int destW);
    return data
         | (strb << dataW)
         | (keep << (dataW + bytes))
         | (last << (dataW + 2 * bytes))
         | (id   << (dataW + 2 * bytes + 1))
         | (dest << (dataW + 2 * bytes + 1 + idW))
         | (user << (dataW + 2 * bytes + 1 + idW + destW));
  endfunction

  function automatic beatVec_t unpackField(input beatVec_t beat, input int lsb, input int w);
    return (beat >> lsb) & ((beatVec_t'(1) << w) - beatVec_t'(1));
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram
// Simple dual-port storage: one write port, one registered read port.
//   clk, rstN          - clock, async active-low reset (read register only)
//   wrEn/wrAddr/wrData - write port
//   rdEn/rdAddr        - read request; the read register only updates when rdEn=1
//   rdData_p1          - registered read data, doubles as the FIFO output payload register
module axis_fifo_ram
  import axi_stream_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int BEAT_W = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [BEAT_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [AW-1:0]     rdAddr,
  output logic [BEAT_W-1:0] rdData_p1
);

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Stage p1: read register, cleared so the outgoing payload reads zero after reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)     rdData_p1 <= '0;
    else if (rdEn) rdData_p1 <= mem[rdAddr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo
// AXI4-Stream FIFO buffering every channel field, first-word fall-through with a
// registered output stage, optional store-and-forward packet mode.
//   aclk, aresetn  - clock, async active-low reset
//   s_t*           - slave (write) side; s_tReady is registered
//   m_t*           - master (read) side; payload comes straight from the RAM read register
//   level          - beats held, including the one in the output register
module axis_packet_fifo
  import axi_stream_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int UNITS       = 1,
  parameter int TID_W       = 4,
  parameter int TDEST_W     = 0,
  parameter int TUSER_W     = 0,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  localparam int BYTES      = (WIDTH / 8) * UNITS,
  localparam int TID_W_     = clampW(TID_W),
  localparam int TDEST_W_   = clampW(TDEST_W),
  localparam int TUSER_W_   = clampW(TUSER_W),
  localparam int LW         = clog2(DEPTH) + 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_tValid,
  output logic                s_tReady,
  input  logic [8*BYTES-1:0]  s_tData,
  input  logic [BYTES-1:0]    s_tStrb,
  input  logic [BYTES-1:0]    s_tKeep,
  input  logic                s_tLast,
  input  logic [TID_W_-1:0]   s_tId,
  input  logic [TDEST_W_-1:0] s_tDest,
  input  logic [TUSER_W_-1:0] s_tUser,
  output logic                m_tValid,
  input  logic                m_tReady,
  output logic [8*BYTES-1:0]  m_tData,
  output logic [BYTES-1:0]    m_tStrb,
  output logic [BYTES-1:0]    m_tKeep,
  output logic                m_tLast,
  output logic [TID_W_-1:0]   m_tId,
  output logic [TDEST_W_-1:0] m_tDest,
  output logic [TUSER_W_-1:0] m_tUser,
  output logic [LW-1:0]       level
);

  localparam int DATA_W   = 8 * BYTES;
  localparam int AW       = clog2(DEPTH);
  localparam int BEAT_W   = beatWidth(BYTES, TID_W_, TDEST_W_, TUSER_W_);
  localparam int OFF_STRB = DATA_W;
  localparam int OFF_KEEP = DATA_W + BYTES;
  localparam int OFF_LAST = DATA_W + 2 * BYTES;
  localparam int OFF_ID   = OFF_LAST + 1;
  localparam int OFF_DEST = OFF_ID + TID_W_;
  localparam int OFF_USER = OFF_DEST + TDEST_W_;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0]     wrPtr, rdPtr;
  logic [LW-1:0]     pktCnt, memCount, levelNext;
  logic              sReady, mVld_p1, drain;
  logic              wrFire, xferFire, rdFire, lastHeld, escape, pktGate;
  logic [BEAT_W-1:0] wrBeat, rdBeat_p1;
  beatVec_t          inVec, outVec, fData, fStrb, fKeep, fLast, fId, fDest, fUser;
  logic              unusedHi;

  assign s_tReady = sReady;
  assign m_tValid = mVld_p1;

  // Stage p0: serialise the incoming beat for storage
  always_comb begin
    inVec  = packBeat(beatVec_t'(s_tData), beatVec_t'(s_tStrb), beatVec_t'(s_tKeep),
                      beatVec_t'(s_tLast), beatVec_t'(s_tId), beatVec_t'(s_tDest),
                      beatVec_t'(s_tUser), DATA_W, BYTES, TID_W_, TDEST_W_);
    wrBeat = inVec[BEAT_W-1:0];
  end

  always_comb begin
    wrFire    = s_tValid & sReady;
    xferFire  = mVld_p1 & m_tReady;
    memCount  = level - LW'(mVld_p1);
    // A tLast beat sitting in the output register is still counted in pktCnt but
    // says nothing about the beats queued behind it.
    lastHeld  = mVld_p1 & m_tLast;
    // Buffer full of one unfinished packet: nothing would ever free space, so cut through.
    escape    = (PACKET_MODE != 0) && (level == FULL_LVL) && (pktCnt == '0);
    if (PACKET_MODE == 0) pktGate = 1'b1;
    else pktGate = (pktCnt > LW'(lastHeld)) || (drain && !lastHeld) || escape;
    rdFire    = (memCount != '0) && (!mVld_p1 || m_tReady) && pktGate;
    levelNext = level + LW'(wrFire) - LW'(xferFire);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      pktCnt  <= '0;
      sReady  <= 1'b0;
      mVld_p1 <= 1'b0;
      drain   <= 1'b0;
    end else begin
      if (wrFire) wrPtr <= wrPtr + AW'(1);
      if (rdFire) rdPtr <= rdPtr + AW'(1);
      level  <= levelNext;
      sReady <= (levelNext < FULL_LVL);
      pktCnt <= pktCnt + LW'(wrFire & s_tLast) - LW'(xferFire & m_tLast);
      if (rdFire)        mVld_p1 <= 1'b1;
      else if (xferFire) mVld_p1 <= 1'b0;
      if (escape)                   drain <= 1'b1;
      else if (xferFire && m_tLast) drain <= 1'b0;
    end
  end

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .BEAT_W(BEAT_W)
  ) uRam (
    .clk      (aclk),
    .rstN     (aresetn),
    .wrEn     (wrFire),
    .wrAddr   (wrPtr),
    .wrData   (wrBeat),
    .rdEn     (rdFire),
    .rdAddr   (rdPtr),
    .rdData_p1(rdBeat_p1)
  );

  // Stage p1: output register fields, held while the consumer stalls
  always_comb begin
    outVec  = beatVec_t'(rdBeat_p1);
    fData   = unpackField(outVec, 0, DATA_W);
    fStrb   = unpackField(outVec, OFF_STRB, BYTES);
    fKeep   = unpackField(outVec, OFF_KEEP, BYTES);
    fLast   = unpackField(outVec, OFF_LAST, 1);
    fId     = unpackField(outVec, OFF_ID, TID_W_);
    fDest   = unpackField(outVec, OFF_DEST, TDEST_W_);
    fUser   = unpackField(outVec, OFF_USER, TUSER_W_);
    m_tData = fData[DATA_W-1:0];
    m_tStrb = fStrb[BYTES-1:0];
    m_tKeep = fKeep[BYTES-1:0];
    m_tLast = fLast[0];
    m_tId   = fId[TID_W_-1:0];
    m_tDest = fDest[TDEST_W_-1:0];
    m_tUser = fUser[TUSER_W_-1:0];
  end

  // High bits of the wide helper vectors are always zero.
  assign unusedHi = ^{inVec[MAX_BEAT_W-1:BEAT_W], fData[MAX_BEAT_W-1:DATA_W],
                      fStrb[MAX_BEAT_W-1:BYTES], fKeep[MAX_BEAT_W-1:BYTES],
                      fLast[MAX_BEAT_W-1:1], fId[MAX_BEAT_W-1:TID_W_],
                      fDest[MAX_BEAT_W-1:TDEST_W_], fUser[MAX_BEAT_W-1:TUSER_W_]};

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo
// Two instances: uFifoA (DEPTH=4, streaming) and uFifoB (DEPTH=4, packet mode).
module tb_axis_packet_fifo;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int nChecks = 0;
  int nErrors = 0;

  // Instance A: DEPTH=4, PACKET_MODE=0, TUSER_W=2, TDEST_W=0 (clamped to 1)
  logic        aRstN, aS_tValid, aS_tReady, aM_tValid, aM_tReady;
  logic [27:0] aIn, aOut;
  logic [15:0] aS_tData, aM_tData;
  logic [1:0]  aS_tStrb, aS_tKeep, aM_tStrb, aM_tKeep, aS_tUser, aM_tUser;
  logic        aS_tLast, aM_tLast, aS_tDest, aM_tDest;
  logic [3:0]  aS_tId, aM_tId;
  logic [2:0]  aLevel;

  assign {aS_tData, aS_tKeep, aS_tStrb, aS_tLast, aS_tId, aS_tUser, aS_tDest} = aIn;
  assign aOut = {aM_tData, aM_tKeep, aM_tStrb, aM_tLast, aM_tId, aM_tUser, aM_tDest};

  axis_packet_fifo #(.WIDTH(16), .UNITS(1), .TID_W(4), .TDEST_W(0), .TUSER_W(2),
                     .DEPTH(4), .PACKET_MODE(0)) uFifoA (
    .aclk(aclk), .aresetn(aRstN),
    .s_tValid(aS_tValid), .s_tReady(aS_tReady), .s_tData(aS_tData), .s_tStrb(aS_tStrb),
    .s_tKeep(aS_tKeep), .s_tLast(aS_tLast), .s_tId(aS_tId), .s_tDest(aS_tDest),
    .s_tUser(aS_tUser),
    .m_tValid(aM_tValid), .m_tReady(aM_tReady), .m_tData(aM_tData), .m_tStrb(aM_tStrb),
    .m_tKeep(aM_tKeep), .m_tLast(aM_tLast), .m_tId(aM_tId), .m_tDest(aM_tDest),
    .m_tUser(aM_tUser), .level(aLevel)
  );

  // Instance B: DEPTH=4, PACKET_MODE=1
  logic        bRstN, bS_tValid, bS_tReady, bM_tValid, bM_tReady, bS_tLast, bM_tLast;
  logic [15:0] bS_tData, bM_tData;
  logic [1:0]  bS_tStrb, bS_tKeep, bUnusedStrb, bUnusedKeep;
  logic [3:0]  bS_tId, bUnusedId;
  logic        bS_tDest, bS_tUser, bUnusedDest, bUnusedUser;
  logic [2:0]  bLevel;

  axis_packet_fifo #(.WIDTH(16), .UNITS(1), .TID_W(4), .TDEST_W(0), .TUSER_W(0),
                     .DEPTH(4), .PACKET_MODE(1)) uFifoB (
    .aclk(aclk), .aresetn(bRstN),
    .s_tValid(bS_tValid), .s_tReady(bS_tReady), .s_tData(bS_tData), .s_tStrb(bS_tStrb),
    .s_tKeep(bS_tKeep), .s_tLast(bS_tLast), .s_tId(bS_tId), .s_tDest(bS_tDest),
    .s_tUser(bS_tUser),
    .m_tValid(bM_tValid), .m_tReady(bM_tReady), .m_tData(bM_tData), .m_tStrb(bUnusedStrb),
    .m_tKeep(bUnusedKeep), .m_tLast(bM_tLast), .m_tId(bUnusedId), .m_tDest(bUnusedDest),
    .m_tUser(bUnusedUser), .level(bLevel)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Random beats into A; toggle=0 keeps m_tReady high, toggle=1 flips it every cycle.
  task automatic runStream(input int n, input bit toggle);
    logic [27:0] q[$];
    logic [28:0] prevOut;
    logic        acc, holdPrev;
    logic [2:0]  maxLvl;
    int          sent, rcvd, gaps;
    sent = 0; rcvd = 0; gaps = 0; maxLvl = '0; holdPrev = 1'b0; prevOut = '0;
    aM_tReady = 1'b1;
    aIn = 28'($urandom);
    aS_tValid = 1'b1;
    for (int c = 1; c <= 4 * n + 20 && rcvd < n; c++) begin
      acc = aS_tValid && aS_tReady;
      tick();
      if (acc) begin
        q.push_back(aIn);
        sent++;
        if (sent < n) aIn = 28'($urandom);
        else aS_tValid = 1'b0;
      end
      if (!toggle) begin
        if (c == 1) chk("stream latency edge1", 64'(aM_tValid), 64'(0));
        if (c == 2) chk("stream latency edge2", 64'(aM_tValid), 64'(1));
        if (aLevel > maxLvl) maxLvl = aLevel;
      end
      if (toggle && holdPrev)
        chk("bp hold", 64'({aM_tValid, aOut}), 64'(prevOut));
      if (toggle) aM_tReady = ~aM_tReady;
      if (aM_tValid && aM_tReady) begin
        if (q.size() == 0) chk("stream extra beat", 64'(1), 64'(0));
        else chk("stream beat", 64'(aOut), 64'(q.pop_front()));
        rcvd++;
      end else if (!toggle && rcvd > 0) begin
        gaps++;
      end
      holdPrev = aM_tValid && !aM_tReady;
      prevOut  = {aM_tValid, aOut};
    end
    chk("stream count", 64'(rcvd), 64'(n));
    if (!toggle) begin
      chk("stream gaps", 64'(gaps), 64'(0));
      chk("stream max level", 64'(maxLvl), 64'(2));
    end
    tick();
    chk("stream empty after", 64'({aM_tValid, aLevel}), 64'(0));
  endtask

  initial begin : main
    logic       acc;
    logic [2:0] maxL;
    int         sent, rcvd;

    aRstN = 1'b0; bRstN = 1'b0;
    aIn = '0; aS_tValid = 1'b0; aM_tReady = 1'b0;
    bS_tValid = 1'b0; bS_tData = '0; bS_tLast = 1'b0; bM_tReady = 1'b0;
    bS_tStrb = 2'b11; bS_tKeep = 2'b11; bS_tId = '0; bS_tDest = 1'b0; bS_tUser = 1'b0;
    repeat (2) tick();

    chk("rst a sReady", 64'(aS_tReady), 64'(0));
    chk("rst a mValid", 64'(aM_tValid), 64'(0));
    chk("rst a level", 64'(aLevel), 64'(0));
    chk("rst a payload", 64'(aOut), 64'(0));
    chk("rst b sReady/mValid/level", 64'({bS_tReady, bM_tValid, bLevel}), 64'(0));

    aRstN = 1'b1; bRstN = 1'b1;
    #1;
    chk("exit sReady before edge", 64'(aS_tReady), 64'(0));
    tick();
    chk("exit a sReady", 64'(aS_tReady), 64'(1));
    chk("exit b sReady", 64'(bS_tReady), 64'(1));

    // Fill A with 0x11..0x44 while the consumer is stalled
    for (int i = 0; i < 4; i++) begin
      aIn = {16'(17 * (i + 1)), 12'h000};
      aS_tValid = 1'b1;
      tick();
      if (i == 2) chk("fill sReady after 3", 64'(aS_tReady), 64'(1));
    end
    chk("fill level", 64'(aLevel), 64'(4));
    chk("fill sReady", 64'(aS_tReady), 64'(0));
    chk("fill head", 64'({aM_tValid, aM_tData}), 64'({1'b1, 16'h0011}));

    // Full: read and write offered together, write is refused that cycle
    aIn = {16'h0055, 12'h000};
    aM_tReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("full refuse level", 64'(aLevel), 64'(3));
        chk("full refuse sReady", 64'(aS_tReady), 64'(1));
      end
      if (i == 1) aS_tValid = 1'b0;
      if (i < 4) chk($sformatf("drain beat %0d", i), 64'({aM_tValid, aM_tData}),
                     64'({1'b1, 16'h0022 + 16'(17 * i)}));
      else chk("drain empty", 64'({aM_tValid, aLevel}), 64'(0));
    end

    runStream(100, 1'b0);
    runStream(30, 1'b1);

    // Reset mid-packet, asserted between edges
    aIn = {16'h0077, 12'h000};
    aS_tValid = 1'b1;
    aM_tReady = 1'b0;
    repeat (3) tick();
    aS_tValid = 1'b0;
    chk("pre-reset level", 64'(aLevel), 64'(3));
    #2;
    aRstN = 1'b0;
    #1;
    chk("async rst mValid", 64'(aM_tValid), 64'(0));
    chk("async rst level", 64'(aLevel), 64'(0));
    chk("async rst data", 64'(aM_tData), 64'(0));
    tick();
    aRstN = 1'b1;
    tick();
    chk("post-rst sReady", 64'(aS_tReady), 64'(1));
    chk("post-rst empty", 64'({aM_tValid, aLevel}), 64'(0));
    runStream(10, 1'b0);

    // Packet mode: two beats, 2-cycle gap, then the tLast beat
    bM_tReady = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      bS_tValid = (e <= 2 || e == 5);
      bS_tData  = (e == 5) ? 16'h00A3 : 16'h00A0 + 16'(e);
      bS_tLast  = (e == 5);
      tick();
      chk($sformatf("pkt valid edge%0d", e), 64'(bM_tValid), 64'(e >= 6 && e <= 8));
      if (e >= 6 && e <= 8)
        chk($sformatf("pkt beat edge%0d", e), 64'({bM_tData, bM_tLast}),
            64'({16'h00A0 + 16'(e - 5), e == 8}));
    end

    // Packet mode: 6-beat packet into a 4-deep FIFO must escape via cut-through
    sent = 0; rcvd = 0; maxL = '0;
    bS_tData = 16'h00B1; bS_tLast = 1'b0; bS_tValid = 1'b1;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      acc = bS_tValid && bS_tReady;
      tick();
      if (acc) begin
        sent++;
        bS_tData  = 16'h00B1 + 16'(sent);
        bS_tLast  = (sent == 5);
        bS_tValid = (sent < 6);
      end
      if (bLevel > maxL) maxL = bLevel;
      if (bM_tValid) begin
        if (rcvd == 0) chk("oversize released at full", 64'(maxL), 64'(4));
        chk($sformatf("oversize beat %0d", rcvd), 64'({bM_tData, bM_tLast}),
            64'({16'h00B1 + 16'(rcvd), rcvd == 5}));
        rcvd++;
      end
    end
    chk("oversize count", 64'(rcvd), 64'(6));
    tick();
    chk("oversize empty after", 64'({bM_tValid, bLevel}), 64'(0));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Parametrised AXI4-Stream FIFO, the successor to the bare stream channel definition.
- Buffers every channel field: tData, tStrb, tKeep, tLast, tId, tDest, tUser.
- Adds configurable depth, an occupancy output, and optional store-and-forward packet mode.
- Sits between stream producers and consumers to absorb backpressure or to guarantee whole-packet delivery to downstream arbiters.

Parameters:
- WIDTH, 16, bits per unit.
- UNITS, 1, units per beat; BYTES = (WIDTH/8)*UNITS.
- TID_W, 4, ID width; widths below 1 are clamped to 1.
- TDEST_W, 0, destination width; widths below 1 are clamped to 1.
- TUSER_W, 0, user width; widths below 1 are clamped to 1.
- DEPTH, 16, entries; power of two, minimum 2.
- PACKET_MODE, 0, 1 = release a beat only once its packet's tLast beat is stored.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  async reset, active low.
- s_tValid  in  1  slave beat valid.
- s_tReady  out  1  FIFO can accept a beat.
- s_tData  in  8*BYTES  slave data.
- s_tStrb  in  BYTES  slave strobe.
- s_tKeep  in  BYTES  slave keep.
- s_tLast  in  1  slave packet end.
- s_tId  in  TID_W_  slave ID.
- s_tDest  in  TDEST_W_  slave destination.
- s_tUser  in  TUSER_W_  slave user sideband.
- m_tValid  out  1  master beat valid.
- m_tReady  in  1  downstream ready.
- m_tData  out  8*BYTES  master data.
- m_tStrb  out  BYTES  master strobe.
- m_tKeep  out  BYTES  master keep.
- m_tLast  out  1  master packet end.
- m_tId  out  TID_W_  master ID.
- m_tDest  out  TDEST_W_  master destination.
- m_tUser  out  TUSER_W_  master user sideband.
- level  out  $clog2(DEPTH)+1  beats held, including the output register.

Behaviour:
- Clock and reset: one clock, aclk; reset aresetn is asynchronous, active low.
- Reset values: s_tReady=0, m_tValid=0, level=0, all m_* payload=0, pointers and counters=0.
- Reset exit: s_tReady rises on the first aclk edge after aresetn deasserts.
- Reset mid-operation: contents are discarded and m_tValid drops immediately, without waiting for a clock edge.
- Write side:
  - A beat is accepted when s_tValid & s_tReady.
  - s_tReady = (level < DEPTH), registered; it never depends combinationally on m_tReady.
- Read side:
  - First-word fall-through with a registered output stage.
  - A beat transfers when m_tValid & m_tReady.
  - While m_tValid=1 and m_tReady=0, all m_* outputs hold stable.
- Latency, PACKET_MODE=0: a beat written into an empty FIFO on edge N appears with m_tValid=1 after edge N+1.
- Packet mode, PACKET_MODE=1:
  - pkt_cnt increments on each accepted beat with s_tLast=1 and decrements on each transferred beat with m_tLast=1.
  - The read side may advance a beat only when pkt_cnt>0.
  - Deadlock escape: if level==DEPTH and pkt_cnt==0, the oversize packet drains in cut-through until its tLast beat has transferred.
- Simultaneous events:
  - Write and read in the same cycle: level unchanged, and the pointers wrap modulo DEPTH independently.
  - Full with read and write both presented in one cycle: s_tReady is still 0 that cycle, so the write is refused. Full throughput is restored the next cycle.
  - Empty with a write: no bypass; the one-cycle latency applies.
  - tLast written and read in the same cycle: pkt_cnt unchanged.
- Throughput: one beat per clock sustained when not full and m_tReady=1.

Decomposition:
- Package axi_stream_pkg:
  - clamp-to-1 width function;
  - clog2 helper;
  - beat-width calculation (8*BYTES + 2*BYTES + 1 + ID + DEST + USER);
  - pack and unpack functions that serialise beat fields into one vector.
- Sub-module axis_fifo_ram: simple dual-port, one write port and one registered read port, DEPTH x beat width, no reset on the storage array.
- Top level holds the pointers, level and pkt_cnt logic, the output register, and the packet-mode gate.

Test Plan:
- DEPTH=4, PACKET_MODE=0: write beats 0x11..0x44 with m_tReady=0.
  - s_tReady falls after the 4th write, level=4.
  - Raising m_tReady outputs 0x11, 0x22, 0x33, 0x44 in order.
- Continuous streaming with m_tReady=1, 100 random beats including random tKeep, tId and tUser: output equals input, one beat per clock after 1-cycle latency, level never exceeds 2.
- PACKET_MODE=1: write a 3-beat packet with a 2-cycle gap before tLast.
  - m_tValid stays 0 until the cycle after the tLast beat is written.
  - The packet then streams contiguously.
- PACKET_MODE=1, DEPTH=4: write a 6-beat packet. After level hits 4 with pkt_cnt=0, beats drain and all 6 arrive with tLast on beat 6.
- Backpressure: toggle m_tReady every cycle. m_* outputs stay stable whenever m_tValid=1 and m_tReady=0, and no beat is lost or duplicated.
- Reset mid-packet: assert aresetn low between edges. m_tValid drops immediately, level=0, and post-reset traffic is unaffected by the stale data.
